// File: rtl/banco_registradores_param.sv
// Parametrised register file: two registered read ports, one write port with bypass,
// optional hardwired zero register and a per-register pending-write scoreboard.
module banco_registradores_param #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] regA,
   input  logic [ADDR_W-1:0] regB,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] regC,
   input  logic [DATA_W-1:0] dado,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_reg,
   output logic [DATA_W-1:0] regsaidaA,
   output logic [DATA_W-1:0] regsaidaB,
   output logic              busyA,
   output logic              busyB,
   output logic              busy_any
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [DATA_W-1:0]   mem [NUM_REGS];
   logic [NUM_REGS-1:0] sb;
   logic [NUM_REGS-1:0] sb_cleared;
   logic [NUM_REGS-1:0] sb_next;
   logic                wr_eff;
   logic                iss_eff;
   logic [DATA_W-1:0]   rd_a_val;
   logic [DATA_W-1:0]   rd_b_val;

   function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] a);
      logic [NUM_REGS-1:0] v;
      v    = '0;
      v[a] = 1'b1;
      return v;
   endfunction

   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
      return ZERO_REG && (a == '0);
   endfunction

   always_comb begin
      wr_eff     = wr_en && !is_zero_reg(regC);
      iss_eff    = issue_en && !is_zero_reg(issue_reg);
      // Busy flags sample the scoreboard after the write-clear but before the issue-set.
      sb_cleared = sb & ~(wr_eff ? onehot(regC) : '0);
      sb_next    = sb_cleared | (iss_eff ? onehot(issue_reg) : '0);

      rd_a_val = mem[regA];
      if (wr_eff && (regC == regA)) rd_a_val = dado;
      if (is_zero_reg(regA))        rd_a_val = '0;

      rd_b_val = mem[regB];
      if (wr_eff && (regC == regB)) rd_b_val = dado;
      if (is_zero_reg(regB))        rd_b_val = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
         sb        <= '0;
         regsaidaA <= '0;
         regsaidaB <= '0;
         busyA     <= 1'b0;
         busyB     <= 1'b0;
      end else begin
         if (wr_eff) mem[regC] <= dado;
         sb <= sb_next;
         if (rd_en) begin
            regsaidaA <= rd_a_val;
            regsaidaB <= rd_b_val;
            busyA     <= sb_cleared[regA];
            busyB     <= sb_cleared[regB];
         end
      end
   end

   assign busy_any = |sb;

endmodule
